register_file_mp: RTL and testbench

//  Next-generation ARM core register file: N combinational read ports, two write ports
//  (A: ALU/load writeback, B: base-register writeback), built-in PC incrementer and
//  per-register pending scoreboard for outstanding loads. Sits between decode (reads)
//  and writeback (writes); the pc output feeds instruction fetch.

---
 rtl/register_file_mp.sv | 121 ++++++++++++
 tb/tb_register_file_mp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-ported register file for the core's decode/writeback boundary.
// N combinational read ports, write ports A (ALU/load) and B (base writeback),
// a built-in PC incrementer and a per-register pending bit for outstanding loads.
// Port A beats port B on the same address. A write to the PC register beats
// pc_inc. With BYPASS=1, same-cycle write data (and a port-A pending clear)
// is forwarded to the read ports.
// There is no handshake: reads are combinational and writes always land.
// The caller owns hazard interlock through rd_pending.
module register_file_mp #(
    parameter int WORD_SIZE    = 32,
    parameter int NUM_REGS     = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_RD_PORTS = 3,
    parameter int PC_INDEX     = 15,
    parameter int PC_STEP      = 4,
    parameter bit BYPASS       = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*WORD_SIZE-1:0]  rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_pending,
    input  logic                               wa_en,
    input  logic [ADDR_WIDTH-1:0]              wa_addr,
    input  logic [WORD_SIZE-1:0]               wa_data,
    input  logic                               wb_en,
    input  logic [ADDR_WIDTH-1:0]              wb_addr,
    input  logic [WORD_SIZE-1:0]               wb_data,
    input  logic                               pc_inc,
    input  logic                               pend_set_en,
    input  logic [ADDR_WIDTH-1:0]              pend_set_addr,
    output logic [WORD_SIZE-1:0]               pc,
    output logic                               any_pending
);

    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  pending;

    // Qualified write/set strobes: out-of-range addresses do nothing, B loses to A
    logic wa_live;
    logic wb_live;
    logic ps_live;

    // Decode which writes and pending sets actually take effect this cycle
    always_comb begin
        wa_live = wa_en && (int'(wa_addr) < NUM_REGS);
        wb_live = wb_en && (int'(wb_addr) < NUM_REGS)
                  && !(wa_live && (wa_addr == wb_addr));
        ps_live = pend_set_en && (int'(pend_set_addr) < NUM_REGS);
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic [WORD_SIZE-1:0]  port_data;
            logic                  port_pend;

            assign ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

            // Read mux: forwarded write data first, then stored value; 0 off the end
            always_comb begin
                port_data = '0;
                port_pend = 1'b0;
                if (int'(ra) < NUM_REGS) begin
                    port_data = regs[ra];
                    port_pend = pending[ra];
                    if (BYPASS) begin
                        if (wa_live && (wa_addr == ra)) begin
                            port_data = wa_data;
                            port_pend = 1'b0;
                        end else if (wb_live && (wb_addr == ra)) begin
                            port_data = wb_data;
                        end
                    end
                end
            end

            assign rd_data[k*WORD_SIZE +: WORD_SIZE] = port_data;
            assign rd_pending[k]                     = port_pend;
        end
    endgenerate

    // Register array update: A beats B beats PC increment
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wa_live && (wa_addr == ADDR_WIDTH'(r))) begin
                    regs[r] <= wa_data;
                end else if (wb_live && (wb_addr == ADDR_WIDTH'(r))) begin
                    regs[r] <= wb_data;
                end else if ((r == PC_INDEX) && pc_inc) begin
                    regs[r] <= regs[r] + WORD_SIZE'(PC_STEP);
                end
            end
        end
    end

    // Load scoreboard: a set wins over a same-cycle port-A clear; port B never clears
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ps_live && (pend_set_addr == ADDR_WIDTH'(r))) begin
                    pending[r] <= 1'b1;
                end else if (wa_live && (wa_addr == ADDR_WIDTH'(r))) begin
                    pending[r] <= 1'b0;
                end
            end
        end
    end

    assign pc          = regs[PC_INDEX];
    assign any_pending = |pending;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp (default parameters, BYPASS=1).
// The driver applies one cycle of inputs just after each falling edge.
// It pushes tagged expectations (cycle, output, port, value) into exp_q.
// The monitor wakes 3 ns after the falling edge, checks every entry due in
// the current cycle against the DUT outputs, and removes it.
module tb_register_file_mp;

    localparam int WS = 32;
    localparam int AW = 4;
    localparam int NP = 3;

    localparam int K_DATA = 0;
    localparam int K_PEND = 1;
    localparam int K_PC   = 2;
    localparam int K_ANY  = 3;

    logic               clk;
    logic               reset;
    logic [NP*AW-1:0]   rd_addr;
    logic [NP*WS-1:0]   rd_data;
    logic [NP-1:0]      rd_pending;
    logic               wa_en;
    logic [AW-1:0]      wa_addr;
    logic [WS-1:0]      wa_data;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [WS-1:0]      wb_data;
    logic               pc_inc;
    logic               pend_set_en;
    logic [AW-1:0]      pend_set_addr;
    logic [WS-1:0]      pc;
    logic               any_pending;

    register_file_mp #(
        .WORD_SIZE(32), .NUM_REGS(16), .ADDR_WIDTH(4), .NUM_RD_PORTS(3),
        .PC_INDEX(15), .PC_STEP(4), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pc_inc(pc_inc),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr), .pc(pc),
        .any_pending(any_pending)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] exp;
        int          tid;
    } exp_t;

    exp_t exp_q[$];
    int   cur_cyc  = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input int off, input int kind, input int port,
                        input logic [31:0] v, input int tid);
        exp_t e;
        e.cyc  = cur_cyc + off;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.tid  = tid;
        exp_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [31:0] act;
        string       nm;
        act = '0;
        nm  = "";
        case (e.kind)
            K_DATA:  begin act = rd_data[e.port*WS +: WS];  nm = "rd_data";     end
            K_PEND:  begin act = 32'(rd_pending[e.port]);   nm = "rd_pending";  end
            K_PC:    begin act = pc;                        nm = "pc";          end
            default: begin act = 32'(any_pending);          nm = "any_pending"; end
        endcase
        checks++;
        if (act !== e.exp) begin
            failures++;
            $display("FAIL test%0d %s[%0d] cyc=%0d got=%h expected=%h",
                     e.tid, nm, e.port, e.cyc, act, e.exp);
        end
    endtask

    // Monitor: checks all expectations due this cycle, then drops them
    initial begin
        forever begin
            @(negedge clk);
            #3;
            for (int i = 0; i < exp_q.size(); ) begin
                if (exp_q[i].cyc == cur_cyc) begin
                    check(exp_q[i]);
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        cur_cyc++;
        reset         = 1'b0;
        wa_en         = 1'b0;
        wa_addr       = '0;
        wa_data       = '0;
        wb_en         = 1'b0;
        wb_addr       = '0;
        wb_data       = '0;
        pc_inc        = 1'b0;
        pend_set_en   = 1'b0;
        pend_set_addr = '0;
        rd_addr       = '0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr_a(input int a, input logic [31:0] d);
        wa_en = 1'b1; wa_addr = AW'(a); wa_data = d;
    endtask

    task automatic wr_b(input int a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = AW'(a); wb_data = d;
    endtask

    task automatic pend_set(input int a);
        pend_set_en = 1'b1; pend_set_addr = AW'(a);
    endtask

    // ---------------- reference model for the random phase ----------------
    logic [31:0] m_regs [16];
    logic [15:0] m_pend;

    task automatic model_clear();
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_pend = '0;
    endtask

    // Push this cycle's expected outputs from model state and the driven inputs
    task automatic model_expect(input int tid);
        int          a;
        logic [31:0] d;
        logic        p;
        for (int k = 0; k < NP; k++) begin
            a = int'(rd_addr[k*AW +: AW]);
            d = m_regs[a];
            p = m_pend[a];
            if (wa_en && int'(wa_addr) == a) begin
                d = wa_data;
                p = 1'b0;
            end else if (wb_en && int'(wb_addr) == a) begin
                d = wb_data;
            end
            push(0, K_DATA, k, d, tid);
            push(0, K_PEND, k, 32'(p), tid);
        end
        push(0, K_PC, 0, m_regs[15], tid);
        push(0, K_ANY, 0, 32'(|m_pend), tid);
    endtask

    // Advance the model by one clock edge
    task automatic model_clock();
        logic pc_hit;
        if (reset) begin
            model_clear();
        end else begin
            pc_hit = (wa_en && wa_addr == 4'd15) || (wb_en && wb_addr == 4'd15);
            if (pc_inc && !pc_hit) m_regs[15] = m_regs[15] + 32'd4;
            if (wb_en) m_regs[wb_addr] = wb_data;
            if (wa_en) begin
                m_regs[wa_addr] = wa_data;
                m_pend[wa_addr] = 1'b0;
            end
            if (pend_set_en) m_pend[pend_set_addr] = 1'b1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: stimulus did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        step();

        // T1: reset clears everything
        reset = 1'b1;
        step();
        set_rd(0, 0); set_rd(1, 3); set_rd(2, 15);
        for (int k = 0; k < NP; k++) begin
            push(0, K_DATA, k, 32'h0, 1);
            push(0, K_PEND, k, 32'h0, 1);
        end
        push(0, K_PC, 0, 32'h0, 1);
        push(0, K_ANY, 0, 32'h0, 1);

        // T2: same-cycle write to r3 is forwarded; r4 untouched
        step();
        wr_a(3, 32'hDEADBEEF);
        set_rd(0, 3); set_rd(1, 4);
        push(0, K_DATA, 0, 32'hDEADBEEF, 2);
        push(0, K_DATA, 1, 32'h0, 2);
        step();
        set_rd(0, 3);
        push(0, K_DATA, 0, 32'hDEADBEEF, 2);

        // T3: A beats B on r5; B alone to r6 forwards and stores
        step();
        wr_a(5, 32'h11); wr_b(5, 32'h22);
        set_rd(0, 5); set_rd(2, 5);
        push(0, K_DATA, 0, 32'h11, 3);
        push(0, K_DATA, 2, 32'h11, 3);
        step();
        set_rd(1, 5);
        push(0, K_DATA, 1, 32'h11, 3);
        step();
        wr_b(6, 32'h66);
        set_rd(2, 6);
        push(0, K_DATA, 2, 32'h66, 3);
        step();
        set_rd(0, 6);
        push(0, K_DATA, 0, 32'h66, 3);

        // T4: PC wrap, write-over-increment, pc output never bypassed
        step();
        wr_a(15, 32'hFFFFFFFC);
        push(0, K_PC, 0, 32'h0, 4);
        push(1, K_PC, 0, 32'hFFFFFFFC, 4);
        step();
        pc_inc = 1'b1;
        set_rd(0, 15);
        push(0, K_DATA, 0, 32'hFFFFFFFC, 4);
        push(1, K_PC, 0, 32'h0, 4);
        step();
        pc_inc = 1'b1;
        wr_a(15, 32'h100);
        set_rd(1, 15);
        push(0, K_DATA, 1, 32'h100, 4);
        push(1, K_PC, 0, 32'h100, 4);
        step();
        pc_inc = 1'b1;
        wr_b(15, 32'h200);
        push(1, K_PC, 0, 32'h200, 4);
        step();
        pc_inc = 1'b1;
        push(1, K_PC, 0, 32'h204, 4);

        // T5: pending scoreboard on r2
        step();
        pend_set(2);
        set_rd(0, 2);
        push(0, K_PEND, 0, 32'h0, 5);
        push(0, K_ANY, 0, 32'h0, 5);
        step();
        set_rd(0, 2);
        wr_b(2, 32'h2B);
        push(0, K_PEND, 0, 32'h1, 5);
        push(0, K_ANY, 0, 32'h1, 5);
        step();
        set_rd(0, 2);
        push(0, K_PEND, 0, 32'h1, 5);
        push(0, K_DATA, 0, 32'h2B, 5);
        step();
        wr_a(2, 32'h2A);
        set_rd(0, 2);
        push(0, K_PEND, 0, 32'h0, 5);
        push(0, K_DATA, 0, 32'h2A, 5);
        push(0, K_ANY, 0, 32'h1, 5);
        step();
        set_rd(0, 2);
        push(0, K_PEND, 0, 32'h0, 5);
        push(0, K_ANY, 0, 32'h0, 5);
        step();
        pend_set(2);
        wr_a(2, 32'h3C);
        step();
        set_rd(0, 2);
        push(0, K_PEND, 0, 32'h1, 5);
        push(0, K_ANY, 0, 32'h1, 5);
        push(0, K_DATA, 0, 32'h3C, 5);

        // T6: reset discards pending state and register contents
        step();
        pend_set(7);
        wr_b(7, 32'h77);
        step();
        reset = 1'b1;
        step();
        set_rd(0, 7); set_rd(1, 2); set_rd(2, 15);
        for (int k = 0; k < NP; k++) begin
            push(0, K_DATA, k, 32'h0, 6);
            push(0, K_PEND, k, 32'h0, 6);
        end
        push(0, K_PC, 0, 32'h0, 6);
        push(0, K_ANY, 0, 32'h0, 6);

        // T7: random traffic against the reference model
        step();
        reset = 1'b1;
        model_clear();
        for (int n = 0; n < 1000; n++) begin
            step();
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
            end else begin
                wa_en         = 1'($urandom_range(0, 1));
                wa_addr       = AW'($urandom_range(0, 15));
                wa_data       = $urandom;
                wb_en         = 1'($urandom_range(0, 1));
                wb_addr       = AW'($urandom_range(0, 15));
                wb_data       = $urandom;
                pc_inc        = 1'($urandom_range(0, 1));
                pend_set_en   = ($urandom_range(0, 3) == 0);
                pend_set_addr = AW'($urandom_range(0, 15));
            end
            for (int k = 0; k < NP; k++) set_rd(k, int'($urandom_range(0, 15)));
            model_expect(7);
            model_clock();
        end

        step();
        step();
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
            failures++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
